noc_switch_alloc: RTL and testbench
===================================

Name: noc_switch_alloc

Overview:
- Router stage directly downstream of the five input buffers (N, S, E, W, L).
- Consumes each buffer's head flit and computes an XY route from the destination field.
- Arbitrates per output port with round-robin and pops the winning buffers.
- Registers winning flits into five output slots with valid/ready handshake toward the link or neighbour router.

Parameters:
X_ADDR, 3'd0, this router's X coordinate in the mesh
Y_ADDR, 3'd0, this router's Y coordinate in the mesh
FLIT_W, 16, flit width (fixed by the buffer stage; other values unsupported)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
head_i  in  5*FLIT_W  packed head flits; slice k is bits [16k+15:16k]; k = 0 N, 1 S, 2 E, 3 W, 4 L
head_vld_i  in  5  bit k = buffer k non-empty, so head_i slice k is valid
pop_req_o  in/out: out  5  bit k = pop buffer k at the next clk edge
out_flit_o  out  5*FLIT_W  registered output flits, same index mapping
out_vld_o  out  5  bit k = out_flit_o slice k is valid
out_rdy_i  in  5  bit k = downstream accepts slice k this cycle

Behaviour:
- Flit format: [15:13] dst_x, [12:10] dst_y, [9:0] payload. All packets are single-flit, with no wormhole state.
- Route compute is combinational, per valid input:
  - dst_x > X_ADDR -> E(2); dst_x < X_ADDR -> W(3).
  - Otherwise dst_y > Y_ADDR -> N(0); dst_y < Y_ADDR -> S(1).
  - Otherwise -> L(4).
  - Comparisons are unsigned, 3-bit. There is no U-turn or out-of-mesh check; the flit is routed as computed.
- Slot free condition: output slot k is free when out_vld_o[k]==0 or out_rdy_i[k]==1 in the same cycle.
- Arbitration:
  - There is one round-robin arbiter per output, with a 3-bit pointer ptr[k] in 0..4.
  - Requesters are inputs whose route equals k.
  - Search starts at index ptr[k], increments mod 5, and the first requester wins.
  - A grant is issued only if slot k is free.
  - Each input routes to exactly one output, so an input wins at most one grant per cycle.
  - Up to five grants per cycle in parallel.
- Pop:
  - pop_req_o[i] = 1 combinationally in the cycle input i is granted; 0 otherwise.
  - A flit is popped exactly once.
  - A losing input keeps its head and re-requests next cycle.
- Output register update per slot k at posedge:
  - On a grant: out_flit_o[k] <= winner flit, out_vld_o[k] <= 1, ptr[k] <= (winner+1) mod 5.
  - Else, if out_rdy_i[k]: out_vld_o[k] <= 0, and the flit value is held.
  - Else: hold everything.
- Latency: a head valid and granted in cycle t appears on out_flit_o/out_vld_o after posedge t+1. With a free slot, throughput is 1 flit/cycle per output.
- Simultaneous accept and grant: when the slot is valid with out_rdy_i[k]=1 and a new grant occurs, the new flit replaces the old one in the same edge, giving back-to-back valids with no bubble.
- out_rdy_i[k] while out_vld_o[k]=0 is ignored.
- Backpressure:
  - While out_vld_o[k]=1 and out_rdy_i[k]=0, out_flit_o[k] stays stable.
  - There is no grant to k and no pop of its requesters.
  - ptr[k] is unchanged.
- Reset:
  - While rst=1: pop_req_o = 0 (gated combinationally), out_vld_o = 0, out_flit_o = 0, all ptr = 0.
  - Reset mid-operation discards registered flits. Buffers are not popped during reset.
  - The first grants can occur in the cycle after rst falls.

Test Plan:
- Reset: X_ADDR=1, Y_ADDR=1, head_vld_i=5'h1F, rst held 3 cycles -> pop_req_o=0 and out_vld_o=0 throughout; ptr=0.
- Single route: L head = 16'h44AB (dst 2,1), vld only bit 4 -> pop_req_o=5'b10000 for one cycle; next cycle out_vld_o[2]=1, east slice = 16'h44AB.
- Round-robin: N, S, W all hold dst (2,1) continuously, out_rdy_i=all 1 -> grants/pops in the order N, S, W on three consecutive cycles; east output carries the three flits back-to-back with no bubble.
- Backpressure: east slot valid, out_rdy_i[2]=0 for 4 cycles while N requests east -> pop_req_o[0]=0 and the east flit is stable for 4 cycles. out_rdy_i[2]=1 -> N granted that cycle, new flit next edge.
- Parallel + local:
  - N head dst (1,1) and E head dst (0,1) in the same cycle -> pop_req_o=5'b00101.
  - Next cycle out_vld_o[4]=1 and out_vld_o[3]=1 with the matching flits.
- Reset mid-flow: rst asserted during the round-robin scenario -> out_vld_o=0 the next cycle; after release, arbitration restarts from N (ptr=0).

Source files
------------

// File: rtl/noc_switch_alloc.sv
// noc_switch_alloc: XY route compute, per-output round-robin switch allocation
// and registered output slots with a valid/ready handshake. It sits directly
// behind the five input buffers (N, S, E, W, L) and pops the heads that win.
// Flits are 16 bits: [15:13] dst_x, [12:10] dst_y, [9:0] payload.

module noc_switch_alloc #(
    parameter logic [2:0] X_ADDR = 3'd0,
    parameter logic [2:0] Y_ADDR = 3'd0,
    // Set by the buffer stage. Only 16 is supported.
    parameter int         FLIT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5*FLIT_W-1:0] head_i,
    input  logic [4:0]          head_vld_i,
    output logic [4:0]          pop_req_o,
    output logic [5*FLIT_W-1:0] out_flit_o,
    output logic [4:0]          out_vld_o,
    input  logic [4:0]          out_rdy_i
);

    localparam int NP = 5;

    // Port indices. They are shared by inputs and outputs.
    localparam logic [2:0] P_N = 3'd0;
    localparam logic [2:0] P_S = 3'd1;
    localparam logic [2:0] P_E = 3'd2;
    localparam logic [2:0] P_W = 3'd3;
    localparam logic [2:0] P_L = 3'd4;

    // Route of each input head, and the request mask seen by each output.
    logic [2:0]          route     [NP];
    logic [NP-1:0]       req       [NP];

    // Arbitration results per output.
    logic [NP-1:0]       slot_free;
    logic [NP-1:0]       grant_vld;
    logic [2:0]          grant_idx [NP];

    // Registered output slots and round-robin pointers.
    logic [NP*FLIT_W-1:0] out_flit_q, out_flit_d;
    logic [NP-1:0]        out_vld_q,  out_vld_d;
    logic [2:0]           ptr_q [NP];
    logic [2:0]           ptr_d [NP];

    // XY route compute. X is resolved first, then Y, and a match on both goes local.
    always_comb begin
        // NOTE: combinational blocks assign every output a default before any
        // branch. Without the default, some path would leave a value unassigned
        // and synthesis would infer a latch.
        for (int i = 0; i < NP; i++) begin
            route[i] = P_L;
        end
        for (int i = 0; i < NP; i++) begin
            logic [2:0] dst_x;
            logic [2:0] dst_y;
            dst_x = head_i[i*FLIT_W + FLIT_W-3 +: 3];
            dst_y = head_i[i*FLIT_W + FLIT_W-6 +: 3];
            if (dst_x > X_ADDR) begin
                route[i] = P_E;
            end else if (dst_x < X_ADDR) begin
                route[i] = P_W;
            end else if (dst_y > Y_ADDR) begin
                route[i] = P_N;
            end else if (dst_y < Y_ADDR) begin
                route[i] = P_S;
            end else begin
                route[i] = P_L;
            end
        end
    end

    // Build each output's request mask from the valid inputs routed to it.
    always_comb begin
        for (int k = 0; k < NP; k++) begin
            req[k] = '0;
            for (int i = 0; i < NP; i++) begin
                req[k][i] = head_vld_i[i] && (route[i] == 3'(k));
            end
        end
    end

    // Output slot k can take a new flit when it is empty or being drained this cycle.
    always_comb begin
        for (int k = 0; k < NP; k++) begin
            slot_free[k] = !out_vld_q[k] || out_rdy_i[k];
        end
    end

    // Round-robin search per output. It starts at ptr and wraps mod 5. Reset suppresses all grants.
    always_comb begin
        for (int k = 0; k < NP; k++) begin
            logic found;
            int   idx;
            found        = 1'b0;
            idx          = 0;
            grant_idx[k] = '0;
            for (int off = 0; off < NP; off++) begin
                idx = int'(ptr_q[k]) + off;
                if (idx >= NP) begin
                    idx = idx - NP;
                end
                if (!found && req[k][idx]) begin
                    found        = 1'b1;
                    grant_idx[k] = 3'(idx);
                end
            end
            grant_vld[k] = found && slot_free[k] && !rst;
        end
    end

    // Pop each winning input. An input routes to a single output, so it gets at most one grant.
    always_comb begin
        pop_req_o = '0;
        for (int k = 0; k < NP; k++) begin
            if (grant_vld[k]) begin
                pop_req_o[grant_idx[k]] = 1'b1;
            end
        end
    end

    // Next state of the output slots and pointers.
    // A grant overwrites the slot. A drain with no grant clears only the valid bit.
    always_comb begin
        out_flit_d = out_flit_q;
        out_vld_d  = out_vld_q;
        for (int k = 0; k < NP; k++) begin
            ptr_d[k] = ptr_q[k];
            if (grant_vld[k]) begin
                out_flit_d[k*FLIT_W +: FLIT_W] = head_i[int'(grant_idx[k])*FLIT_W +: FLIT_W];
                out_vld_d[k]                   = 1'b1;
                ptr_d[k]                       = (grant_idx[k] == P_L) ? P_N : grant_idx[k] + 3'd1;
            end else if (out_rdy_i[k]) begin
                out_vld_d[k] = 1'b0;
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register
        // samples pre-edge values. Blocking here would create order-dependent races.
        if (rst) begin
            // NOTE: the flit slots are reset along with the valid bits. A reset
            // must leave out_flit_o at zero, so they are not left uninitialised
            // like plain data storage.
            out_flit_q <= '0;
            out_vld_q  <= '0;
            for (int k = 0; k < NP; k++) begin
                ptr_q[k] <= '0;
            end
        end else begin
            out_flit_q <= out_flit_d;
            out_vld_q  <= out_vld_d;
            for (int k = 0; k < NP; k++) begin
                ptr_q[k] <= ptr_d[k];
            end
        end
    end

    assign out_flit_o = out_flit_q;
    assign out_vld_o  = out_vld_q;

    // Pointer range and backpressure invariants.
    for (genvar k = 0; k < NP; k++) begin : g_chk
        a_ptr_range : assert property (@(posedge clk) disable iff (rst)
            ptr_q[k] < 3'd5);
        a_stall_hold : assert property (@(posedge clk) disable iff (rst)
            (out_vld_q[k] && !out_rdy_i[k]) |=> ($stable(out_flit_q[k*FLIT_W +: FLIT_W]) && out_vld_q[k]));
    end

endmodule

// File: tb/tb_noc_switch_alloc.sv
// Testbench for noc_switch_alloc (X_ADDR=1, Y_ADDR=1).
// It applies a directed vector table first, then randomized traffic checked against a behavioural model.

module tb_noc_switch_alloc;

    localparam logic [2:0] XA = 3'd1;
    localparam logic [2:0] YA = 3'd1;

    logic        clk = 1'b0;
    logic        rst;
    logic [79:0] head_i;
    logic [4:0]  head_vld_i;
    logic [4:0]  pop_req_o;
    logic [79:0] out_flit_o;
    logic [4:0]  out_vld_o;
    logic [4:0]  out_rdy_i;

    int checks   = 0;
    int failures = 0;

    noc_switch_alloc #(.X_ADDR(XA), .Y_ADDR(YA), .FLIT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .head_i     (head_i),
        .head_vld_i (head_vld_i),
        .pop_req_o  (pop_req_o),
        .out_flit_o (out_flit_o),
        .out_vld_o  (out_vld_o),
        .out_rdy_i  (out_rdy_i)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [79:0] pack5(input logic [15:0] n, s, e, w, l);
        return {l, w, e, s, n};
    endfunction

    function automatic logic [15:0] fl(input int x, input int y, input int p);
        logic [15:0] f;
        f = {3'(x), 3'(y), 10'(p)};
        return f;
    endfunction

    typedef struct {
        logic        rst;
        logic [79:0] heads;
        logic [4:0]  vld;
        logic [4:0]  rdy;
        logic [4:0]  exp_pop;   // combinational, same cycle
        logic [4:0]  exp_vld;   // after the edge
        int          slot;      // slot whose flit is checked after the edge
        logic [15:0] exp_flit;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic [79:0] h, input logic [4:0] v,
                                input logic [4:0] rd, input logic [4:0] ep, input logic [4:0] ev,
                                input int sl, input logic [15:0] ef);
        vec_t t;
        t.rst = r; t.heads = h; t.vld = v; t.rdy = rd;
        t.exp_pop = ep; t.exp_vld = ev; t.slot = sl; t.exp_flit = ef;
        return t;
    endfunction

    // Behavioural reference. Each output keeps its slot contents and rotation pointer.
    int          m_ptr  [5];
    logic        m_vld  [5];
    logic [15:0] m_flit [5];

    function automatic int dest_port(input logic [15:0] f);
        int x, y;
        x = int'(f[15:13]);
        y = int'(f[12:10]);
        if (x > int'(XA)) return 2;
        if (x < int'(XA)) return 3;
        if (y > int'(YA)) return 0;
        if (y < int'(YA)) return 1;
        return 4;
    endfunction

    initial begin
        logic [15:0] bh [5];
        logic [4:0]  bv;
        int          win [5];
        logic [4:0]  epop, evld;
        logic [79:0] eflit;
        logic        r;
        logic [4:0]  rdy;

        rst = 1'b1; head_i = '0; head_vld_i = '0; out_rdy_i = '1;

        // ---------------- directed vector table ----------------
        begin
            logic [15:0] e1, fn, fs, fw, fn2, fp_l, fp_w;
            logic [79:0] all_e1, rr;
            e1   = 16'h44AB;               // dst (2,1) -> E
            fn   = fl(2, 1, 1);
            fs   = fl(2, 1, 2);
            fw   = fl(2, 1, 3);
            fn2  = fl(2, 1, 4);
            fp_l = fl(1, 1, 'h11);         // -> L
            fp_w = fl(0, 1, 'h22);         // -> W
            all_e1 = pack5(e1, e1, e1, e1, e1);
            rr     = pack5(fn, fs, 16'h0, fw, 16'h0);
            // Reset held for 3 cycles with every head valid.
            for (int i = 0; i < 3; i++)
                vecs.push_back(mk(1, all_e1, 5'h1F, 5'h1F, 5'h00, 5'h00, 2, 16'h0));
            // Single route from L to E.
            vecs.push_back(mk(0, pack5(0, 0, 0, 0, e1), 5'b10000, 5'h1F, 5'b10000, 5'b00100, 2, e1));
            vecs.push_back(mk(0, '0, 5'h00, 5'h1F, 5'h00, 5'h00, 2, e1));
            // Round-robin N, S, W into E, back-to-back.
            vecs.push_back(mk(0, rr, 5'b01011, 5'h1F, 5'b00001, 5'b00100, 2, fn));
            vecs.push_back(mk(0, rr, 5'b01011, 5'h1F, 5'b00010, 5'b00100, 2, fs));
            vecs.push_back(mk(0, rr, 5'b01011, 5'h1F, 5'b01000, 5'b00100, 2, fw));
            // E backpressured for 4 cycles while N requests E.
            for (int i = 0; i < 4; i++)
                vecs.push_back(mk(0, pack5(fn2, 0, 0, 0, 0), 5'b00001, 5'b11011, 5'h00, 5'b00100, 2, fw));
            vecs.push_back(mk(0, pack5(fn2, 0, 0, 0, 0), 5'b00001, 5'h1F, 5'b00001, 5'b00100, 2, fn2));
            // Parallel grants: N to L and E to W.
            vecs.push_back(mk(0, pack5(fp_l, 0, fp_w, 0, 0), 5'b00101, 5'h1F, 5'b00101, 5'b11000, 4, fp_l));
            vecs.push_back(mk(0, '0, 5'h00, 5'h00, 5'h00, 5'b11000, 3, fp_w));
            vecs.push_back(mk(0, '0, 5'h00, 5'h1F, 5'h00, 5'h00, 3, fp_w));
            // Round-robin again. ptr[E]=1, so S wins. Then a reset, after which N wins.
            vecs.push_back(mk(0, rr, 5'b01011, 5'h1F, 5'b00010, 5'b00100, 2, fs));
            vecs.push_back(mk(1, rr, 5'b01011, 5'h1F, 5'h00, 5'h00, 2, 16'h0));
            vecs.push_back(mk(0, rr, 5'b01011, 5'h1F, 5'b00001, 5'b00100, 2, fn));
        end

        foreach (vecs[n]) begin
            rst = vecs[n].rst; head_i = vecs[n].heads;
            head_vld_i = vecs[n].vld; out_rdy_i = vecs[n].rdy;
            #3;
            check($sformatf("vec%0d_pop", n), 80'(pop_req_o), 80'(vecs[n].exp_pop));
            @(posedge clk); #1;
            check($sformatf("vec%0d_vld", n), 80'(out_vld_o), 80'(vecs[n].exp_vld));
            check($sformatf("vec%0d_flit", n), 80'(out_flit_o[vecs[n].slot*16 +: 16]),
                  80'(vecs[n].exp_flit));
        end

        // ---------------- randomized traffic against the model ----------------
        rst = 1'b1; head_vld_i = '0;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            m_ptr[k] = 0; m_vld[k] = 1'b0; m_flit[k] = '0;
        end
        bv = '0;
        for (int i = 0; i < 5; i++) bh[i] = 16'($urandom);

        for (int cyc = 0; cyc < 500; cyc++) begin
            r = ($urandom_range(0, 39) == 0);
            for (int i = 0; i < 5; i++) begin
                if (!bv[i] && $urandom_range(0, 1) == 1) begin
                    bv[i] = 1'b1;
                    bh[i] = 16'($urandom);
                end
            end
            for (int k = 0; k < 5; k++) rdy[k] = ($urandom_range(0, 9) < 7);
            rst = r; head_vld_i = bv; out_rdy_i = rdy;
            head_i = pack5(bh[0], bh[1], bh[2], bh[3], bh[4]);

            // The winner for output k is the requester closest to ptr[k], going upward mod 5.
            epop = '0;
            for (int k = 0; k < 5; k++) begin
                int best_d;
                win[k] = -1;
                best_d = 5;
                for (int i = 0; i < 5; i++) begin
                    if (bv[i] && dest_port(bh[i]) == k && ((i - m_ptr[k] + 5) % 5) < best_d) begin
                        best_d = (i - m_ptr[k] + 5) % 5;
                        win[k] = i;
                    end
                end
                if (r || (m_vld[k] && !rdy[k])) win[k] = -1;
                if (win[k] >= 0) epop[win[k]] = 1'b1;
            end
            evld = '0; eflit = '0;
            for (int k = 0; k < 5; k++) begin
                evld[k] = m_vld[k];
                eflit[k*16 +: 16] = m_flit[k];
            end

            #3;
            check("rand_pop", 80'(pop_req_o), 80'(epop));
            check("rand_vld", 80'(out_vld_o), 80'(evld));
            check("rand_flit", out_flit_o, eflit);

            // Apply the edge to the model and to the input buffers.
            for (int k = 0; k < 5; k++) begin
                if (r) begin
                    m_vld[k] = 1'b0; m_flit[k] = '0; m_ptr[k] = 0;
                end else if (win[k] >= 0) begin
                    m_vld[k]  = 1'b1;
                    m_flit[k] = bh[win[k]];
                    m_ptr[k]  = (win[k] + 1) % 5;
                end else if (rdy[k]) begin
                    m_vld[k] = 1'b0;
                end
            end
            for (int i = 0; i < 5; i++) begin
                if (epop[i]) begin
                    bv[i] = ($urandom_range(0, 1) == 1);
                    bh[i] = 16'($urandom);
                end
            end
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
